// File: rtl/msk_share_fifo.sv
// FIFO of masked sharing words. Each word is stored and returned share-for-share, with no recombination.
// Define MSK_SHARE_FIFO_ZEROIZE_EN to clear storage on reset and to zero each slot when it is popped.
module msk_share_fifo #(
    parameter int d     = 1,
    parameter int count = 1,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [count*d-1:0]           in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [count*d-1:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int W  = count * d;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    // Handshake flags decode level only, so nothing depends combinationally on in_valid or out_ready.
    assign in_ready  = (level_q < LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
`ifdef MSK_SHARE_FIFO_ZEROIZE_EN
        if (pop) mem_d[rd_ptr_q] = '0;
`endif
        // A push into the slot being popped wins over the zero write.
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef MSK_SHARE_FIFO_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`endif

endmodule

// File: tb/tb_msk_share_fifo.sv
// Self-checking bench for msk_share_fifo (d=2, count=4, DEPTH=4): directed scenarios plus random traffic
// compared every cycle against a queue model.
module tb_msk_share_fifo;
    localparam int D = 2, CNT = 4, DEPTH = 4, W = D * CNT;

    logic         clk, rst_n;
    logic [W-1:0] in_data, out_data;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   level;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];

    msk_share_fifo #(.d(D), .count(CNT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of words, bounded at DEPTH, cleared on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            automatic bit do_pop  = out_ready && (q.size() > 0);
            automatic bit do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        chk("level", 32'(level), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef MSK_SHARE_FIFO_ZEROIZE_EN
        else chk("out_data_zero_empty", 32'(out_data), 32'h0);
`endif
    end

    task automatic cyc(input logic iv, input logic [W-1:0] dat, input logic ordy);
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Two words held, then drained.
        cyc(1, 8'h5A, 0);
        cyc(1, 8'hC3, 0);
        in_valid = 1'b0;
        chk("s1_level", 32'(level), 32'd2);
        chk("s1_head", 32'(out_data), 32'h5A);
        cyc(0, 8'h00, 1);
        chk("s1_second", 32'(out_data), 32'hC3);
        cyc(0, 8'h00, 1);
        chk("s1_empty", 32'(out_valid), 32'h0);

        // Full: a simultaneous pop must not admit a push.
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0);
        chk("s2_full_ready", 32'(in_ready), 32'h0);
        chk("s2_full_level", 32'(level), 32'd4);
        cyc(1, 8'hEE, 1);
        chk("s2_level_after", 32'(level), 32'd3);
        chk("s2_head", 32'(out_data), 32'h21);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
        chk("s2_drained", 32'(out_valid), 32'h0);

        // Empty: no bypass of the word pushed this cycle.
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        #1 chk("s3_no_bypass", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("s3_valid_next", 32'(out_valid), 32'h1);
        chk("s3_data_next", 32'(out_data), 32'h11);
        cyc(0, 8'h00, 0);

        // Streaming through pointer wrap at constant occupancy.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'(8'h80 + i), 1);
            chk("s4_level", 32'(level), 32'd1);
            chk("s4_order", 32'(out_data), 32'(8'h80 + i));
        end
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        // Mid-operation reset between edges.
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(out_valid), 32'h0);
        chk("s5_rst_level", 32'(level), 32'h0);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h7E;
        @(negedge clk);
        in_valid = 1'b0;
        chk("s5_first_out", 32'(out_data), 32'h7E);
        chk("s5_level", 32'(level), 32'd1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

`ifdef MSK_SHARE_FIFO_ZEROIZE_EN
        cyc(1, 8'hFF, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) chk("s6_slot_zero", 32'(dut.mem_q[i]), 32'h0);
        chk("s6_out_zero", 32'(out_data), 32'h0);
`endif

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 500; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 99) < 45));
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 1);
        chk("final_empty", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/msk_share_fifo.md
MSK_SHARE_FIFO -- requirements
Module: msk_share_fifo

Interface
REQ-001 The block SHALL have parameter d, default 1: number of shares per masked bit.
REQ-002 The block SHALL have parameter count, default 1: number of masked bits per word.
REQ-003 The block SHALL have parameter DEPTH, default 4: word slots; power of two, 2..16.
REQ-004 The block SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_data  input  count*d: incoming sharing word, share-major layout identical to the masked register output.
REQ-007 The block SHALL have port in_valid  input  1: in_data holds a word to store.
REQ-008 The block SHALL have port in_ready  output  1: the block can accept a word.
REQ-009 The block SHALL have port out_data  output  count*d: oldest stored sharing word.
REQ-010 The block SHALL have port out_valid  output  1: out_data holds a valid word.
REQ-011 The block SHALL have port out_ready  input  1: the consumer takes out_data.
REQ-012 The block SHALL have port level  output  $clog2(DEPTH+1): number of stored words.

Function
REQ-013 A push SHALL occur on a rising edge with in_valid=1 and in_ready=1; a pop SHALL occur with out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL be 1 iff level<DEPTH; out_valid SHALL be 1 iff level>0; both SHALL be registered or pure decodes of level, with no combinational path from in_valid or out_ready.
REQ-015 Order SHALL be first-in first-out; each word SHALL be stored and output share-for-share unmodified, with no share recombination or XOR of shares.
REQ-016 Latency SHALL be 1 cycle: a word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the following cycle.
REQ-017 out_data SHALL be driven directly from a storage register, with no logic between storage and port other than a read-pointer multiplexer.
REQ-018 Write and read pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-019 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged and advance both pointers.
REQ-020 When full, in_ready=0: a push SHALL NOT occur even if a pop occurs in the same cycle; there is no pass-through.
REQ-021 When empty, out_valid=0: the word pushed in the same cycle SHALL NOT be bypassed to out_data.
REQ-022 in_data and out_ready SHALL be ignored while in_valid=0 and out_valid=0 respectively.

Reset
REQ-023 While rst_n=0, the pointers and level SHALL be 0, in_ready SHALL be 1 (after release) and out_valid SHALL be 0, all asynchronously.
REQ-024 Asserting rst_n mid-operation SHALL discard all stored words; the first push after release SHALL be the first word out.
REQ-025 The first push after release SHALL be accepted in the first clk edge with rst_n=1.

Configuration
REQ-026 Macro MSK_SHARE_FIFO_ZEROIZE_EN SHALL control storage clearing; with it defined, reset SHALL clear all storage to 0 and the popped slot SHALL be written to 0 on the pop edge; without it, storage SHALL have no reset and popped slots SHALL retain their data.
REQ-027 With MSK_SHARE_FIFO_ZEROIZE_EN defined, a pop of slot k SHALL force slot k to 0 (the zero write of the popped slot) unless the same edge pushes into slot k, in which case the push SHALL take precedence.
REQ-028 With MSK_SHARE_FIFO_ZEROIZE_EN defined, out_data SHALL be 0 whenever out_valid=0; without the macro, out_data is don't-care whenever out_valid=0.

Verification
REQ-029 The bench SHALL cover this scenario: d=2, count=4, DEPTH=4; push 0x5A then 0xC3 with out_ready=0 -> level=2, out_data=0x5A; assert out_ready -> 0xC3 next cycle, then out_valid=0.
REQ-030 The bench SHALL cover this scenario: fill 4 words -> in_ready=0, level=4; then hold in_valid=1 and out_ready=1 for one cycle -> exactly one pop, no push, level=3.
REQ-031 The bench SHALL cover this scenario: empty FIFO, in_valid=1 with word 0x11 and out_ready=1 -> out_valid=0 that cycle, 0x11 valid the next cycle.
REQ-032 The bench SHALL cover this scenario: stream 20 words with both handshakes held high -> order preserved across pointer wrap, level stays 1.
REQ-033 The bench SHALL cover this scenario: 3 words stored, pulse rst_n low between edges -> out_valid=0 and level=0 immediately; the next pushed word 0x7E is output first.
REQ-034 The bench SHALL cover this scenario: with MSK_SHARE_FIFO_ZEROIZE_EN defined, push 0xFF and pop it -> the slot reads 0 internally and out_data=0 while empty.
